seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised multi-cycle ALU for the MIPS datapath: successor to the single-cycle combinational ALU.
- Keeps the 3-bit operation encoding and adds iterative unsigned multiply, divide and remainder.
- Registers its result and uses a valid/ready handshake on both input and output.
- Sits between the register-file read stage and write-back; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept an operation
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- alu_control  input  3  operation select
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- alu_result  output  WIDTH  registered result
- zero_flag  output  1  alu_result == 0
- busy  output  1  iterative operation in progress

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, alu_result=0, zero_flag=1, busy=0, counter=0.
- Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (unsigned A<B → 1 else 0), 101 MUL (low WIDTH bits of A*B), 011 DIVU, 100 REMU.
- Accept: in_valid && in_ready on a rising edge latches in_a, in_b and alu_control.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On accept of a logic/arith op (000/001/010/110/111): compute, register result, go to DONE. Latency is 1 cycle (out_valid high on the cycle after the accept edge).
  - On accept of MUL/DIVU/REMU: load operands, counter=WIDTH, go to CALC.
- CALC:
  - in_ready=0, busy=1.
  - One iteration per cycle:
    - MUL: shift-add, LSB-first over B.
    - DIVU/REMU: restoring, MSB-first; one trial subtract per cycle on a WIDTH+1-bit partial remainder.
  - Decrement counter. When counter reaches 1 on the current edge, write the result and go to DONE.
  - Total latency from the accept edge to out_valid is WIDTH+1 cycles.
- DONE:
  - out_valid=1; alu_result and zero_flag are held stable.
  - in_ready=0 (no overlap).
  - On out_ready: go to IDLE and drop out_valid the next cycle.
- Divide by zero (in_b==0): no early exit, still WIDTH iterations. DIVU result = all ones; REMU result = in_a.
- Undefined opcode: none exist (all 8 encodings are used).
- zero_flag: registered together with alu_result and always consistent with it.
- Wrap-around: ADD/SUB/MUL truncate modulo 2^WIDTH and raise no error.
- Signal changes while not accepted: input changes while in_ready=0 are ignored. out_ready while out_valid=0 is ignored.
- Back-to-back operations: a new op is accepted only in IDLE. Minimum throughput is one op per 2 cycles (simple ops).
- Reset mid-operation: CALC or DONE is aborted immediately, all outputs take reset values, and no result is emitted.

Optional Feature:
- Macro: SEQ_ALU_OVF_EN.
- Defined:
  - Adds output port overflow_flag (1 bit), registered with alu_result.
  - Set for ADD when both operands have the same sign and the result sign differs.
  - Set for SUB when the operands differ in sign and the result sign differs from in_a.
  - 0 for all other ops; reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - 3-bit opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, ALU_DIVU, ALU_REMU).
  - FSM state encoding.
  - These are shared with the control unit decoder.
- One sub-module: seq_alu_muldiv.
  - Contains the iterative datapath: partial product/remainder registers, counter, and done pulse.
  - Started by the top FSM.
  - Simple ops stay inline in seq_alu.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1, out_ready=1 → out_valid 1 cycle after accept, result 0x80000000, zero_flag=0; with SEQ_ALU_OVF_EN, overflow_flag=1.
- SUB 5-5 then SLT 3<7 back-to-back → results 0 (zero_flag=1) then 1 (zero_flag=0); second accept occurs no earlier than 2 cycles after the first.
- MUL 0x00010000*0x00010000 and 12345*678 → results 0x00000000 and 8369910; out_valid exactly 33 cycles after accept; busy high for 32 cycles.
- DIVU 100/7 → 14, REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF, REMU 9/0 → 9.
- Output backpressure: hold out_ready=0 for 10 cycles after a result → out_valid, alu_result and zero_flag stay stable and in_ready=0 throughout; release → IDLE the next cycle.
- Assert rst in the middle of a DIVU (cycle 15 of CALC) → out_valid=0, in_ready=1, alu_result=0 immediately; after rst deasserts, a new ADD 2+2 returns 4.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state encoding and helpers shared by the
//               sequential ALU and the control-unit decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_DIVU = 3'b011;
    localparam logic [2:0] ALU_REMU = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Operation select for the iterative datapath
    localparam logic [1:0] MD_MUL = 2'd0;
    localparam logic [1:0] MD_DIV = 2'd1;
    localparam logic [1:0] MD_REM = 2'd2;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic [1:0] md_op_of(input logic [2:0] op);
        case (op)
            ALU_DIVU: return MD_DIV;
            ALU_REMU: return MD_REM;
            default:  return MD_MUL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_muldiv
// Description : Iterative unsigned multiply (shift-add, LSB first) and
//               restoring divide/remainder (MSB first), one step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] C_ITER = CNT_W'(WIDTH);

    // r_acc: partial product (MUL) or partial remainder (DIV/REM)
    // r_q  : remaining multiplier bits (MUL) or dividend->quotient (DIV/REM)
    // r_d  : shifting multiplicand (MUL) or divisor (DIV/REM)
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_active;

    logic [WIDTH:0]   w_acc_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_d_nxt;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_last;

    always_comb begin
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        w_d_nxt   = r_d;
        w_shift   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_d};
        if (r_op == MD_MUL) begin
            w_acc_nxt = {1'b0, r_acc[WIDTH-1:0] + (r_q[0] ? r_d : '0)};
            w_d_nxt   = r_d << 1;
            w_q_nxt   = r_q >> 1;
        end else if (!w_diff[WIDTH]) begin
            w_acc_nxt = w_diff;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_nxt = w_shift;
            w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        w_res = w_acc_nxt[WIDTH-1:0];
        if (r_op == MD_DIV) begin
            w_res = w_q_nxt;
        end
    end

    // The final step's result is handed to the top combinationally so the
    // top can register it on the same edge the counter expires.
    assign w_last = r_active && (r_cnt == CNT_W'(1));
    assign done   = w_last;
    assign result = w_res;
    assign busy   = r_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_op     <= MD_MUL;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_q      <= (op == MD_MUL) ? b : a;
            r_d      <= (op == MD_MUL) ? a : b;
            r_op     <= op;
            r_cnt    <= C_ITER;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_d   <= w_d_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU with valid/ready handshakes; simple ops in one
//               cycle, MUL/DIVU/REMU iteratively. Option: SEQ_ALU_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             busy
`ifdef SEQ_ALU_OVF_EN
    ,
    output logic             overflow_flag
`endif
);

    alu_state_t       r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_accept;
    logic             w_md_start;
    logic             w_md_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [WIDTH-1:0] w_simple;

    // in_ready is only ever set while in IDLE, so it alone gates acceptance
    assign w_accept   = in_valid && r_in_ready;
    assign w_md_start = w_accept && is_iterative(alu_control);

    assign w_sum = in_a + in_b;
    assign w_dif = in_a - in_b;

    always_comb begin
        w_simple = '0;
        case (alu_control)
            ALU_AND: w_simple = in_a & in_b;
            ALU_OR:  w_simple = in_a | in_b;
            ALU_ADD: w_simple = w_sum;
            ALU_SUB: w_simple = w_dif;
            ALU_SLT: w_simple = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            default: w_simple = '0;
        endcase
    end

`ifdef SEQ_ALU_OVF_EN
    logic r_ovf;
    logic w_simple_ovf;

    always_comb begin
        w_simple_ovf = 1'b0;
        if (alu_control == ALU_ADD) begin
            w_simple_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
        end else if (alu_control == ALU_SUB) begin
            w_simple_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_dif[WIDTH-1] != in_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_ovf <= is_iterative(alu_control) ? 1'b0 : w_simple_ovf;
        end
    end

    assign overflow_flag = r_ovf;
`endif

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_md_start),
        .op     (md_op_of(alu_control)),
        .a      (in_a),
        .b      (in_b),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (is_iterative(alu_control)) begin
                            r_state <= ST_CALC;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_simple;
                            r_zero      <= (w_simple == '0);
                        end
                    end
                end
                ST_CALC: begin
                    if (w_md_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_result;
                        r_zero      <= (w_md_result == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign zero_flag  = r_zero;
    assign busy       = w_md_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Scoreboard bench for seq_alu (WIDTH=32), optional SEQ_ALU_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   alu_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero_flag;
    logic         busy;
`ifdef SEQ_ALU_OVF_EN
    logic         overflow_flag;
`endif

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .zero_flag   (zero_flag),
        .busy        (busy)
`ifdef SEQ_ALU_OVF_EN
        ,
        .overflow_flag (overflow_flag)
`endif
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [63:0]  p;
        logic [W-1:0] s;
        e.ovf = 1'b0;
        case (op)
            ALU_AND: e.res = a & b;
            ALU_OR:  e.res = a | b;
            ALU_ADD: begin
                s = a + b;
                e.res = s;
                e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                s = a - b;
                e.res = s;
                e.ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            ALU_SLT: e.res = (a < b) ? 1 : 0;
            ALU_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                e.res = p[W-1:0];
            end
            ALU_DIVU: e.res = (b == 0) ? {W{1'b1}} : a / b;
            default:  e.res = (b == 0) ? a : a % b;
        endcase
        return e;
    endfunction

    // Result monitor: a transfer completes on the edge following this sample
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_result", 64'(alu_result), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", 64'(alu_result), 64'(e.res));
                check_eq("zero_flag", 64'(zero_flag), 64'(e.res == 0));
`ifdef SEQ_ALU_OVF_EN
                check_eq("overflow_flag", 64'(overflow_flag), 64'(e.ovf));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_out);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 0, 1);
        if (expect_out) sb.push_back(model(op, a, b));
        in_valid    = 1'b1;
        alu_control = op;
        in_a        = a;
        in_b        = b;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        in_valid    = 1'b0;
        in_a        = $urandom;
        in_b        = $urandom;
        alu_control = 3'($urandom);
    endtask

    // lat = number of edges from accept to the first edge that sees out_valid
    task automatic wait_valid(output int lat, output int nbusy);
        int n;
        n     = 0;
        nbusy = 0;
        while (!out_valid && n < 200) begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
        end
        if (!out_valid) check_eq("out_valid_timeout", 0, 1);
        lat = cyc - acc_cyc + 1;
    endtask

    int lat, nb, a1, spin;
    logic [W-1:0] snap_res;
    logic         snap_zero, stable;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; alu_control = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 1);
        check_eq("rst_out_valid", 64'(out_valid), 0);
        check_eq("rst_result", 64'(alu_result), 0);
        check_eq("rst_zero", 64'(zero_flag), 1);
        check_eq("rst_busy", 64'(busy), 0);
`ifdef SEQ_ALU_OVF_EN
        check_eq("rst_ovf", 64'(overflow_flag), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
        wait_valid(lat, nb);
        check_eq("add_latency", lat, 1);

        issue(ALU_SUB, 5, 5, 1'b1);
        a1 = acc_cyc;
        issue(ALU_SLT, 3, 7, 1'b1);
        check_eq("b2b_spacing_ge2", 64'((acc_cyc - a1) >= 2), 1);

        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_valid(lat, nb);
        check_eq("mul_latency", lat, 33);
        check_eq("mul_busy_cycles", nb, 32);
        issue(ALU_MUL, 12345, 678, 1'b1);
        wait_valid(lat, nb);
        check_eq("mul2_latency", lat, 33);

        issue(ALU_DIVU, 100, 7, 1'b1);
        wait_valid(lat, nb);
        check_eq("div_latency", lat, 33);
        issue(ALU_REMU, 100, 7, 1'b1);
        issue(ALU_DIVU, 9, 0, 1'b1);
        issue(ALU_REMU, 9, 0, 1'b1);
        issue(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1);
        issue(ALU_OR, 32'hF000_0000, 32'h0000_000F, 1'b1);
        issue(ALU_SUB, 32'h8000_0000, 32'h1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] op;
            logic [W-1:0] ra, rb;
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (op == ALU_DIVU || op == ALU_REMU) ? 32'($urandom_range(1, 5000)) : $urandom;
            issue(op, ra, rb, 1'b1);
        end

        // Output backpressure
        spin = 0;
        while (!in_ready && spin < 200) begin @(negedge clk); spin++; end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        issue(ALU_SUB, 1, 2, 1'b1);
        wait_valid(lat, nb);
        snap_res  = alu_result;
        snap_zero = zero_flag;
        stable    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || alu_result !== snap_res || zero_flag !== snap_zero)
                stable = 1'b0;
        end
        check_eq("backpressure_stable", 64'(stable), 1);
        check_eq("backpressure_value", 64'(snap_res), 64'hFFFF_FFFF);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check_eq("release_out_valid", 64'(out_valid), 0);
        check_eq("release_in_ready", 64'(in_ready), 1);
        @(negedge clk);

        // Reset in the middle of a divide
        issue(ALU_DIVU, 32'hFFFF_0000, 3, 1'b0);
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 0);
        check_eq("midrst_in_ready", 64'(in_ready), 1);
        check_eq("midrst_result", 64'(alu_result), 0);
        check_eq("midrst_busy", 64'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("postrst_no_output", 64'(out_valid), 0);
        issue(ALU_ADD, 2, 2, 1'b1);
        wait_valid(lat, nb);

        spin = 0;
        while (sb.size() != 0 && spin < 200) begin @(negedge clk); spin++; end
        check_eq("scoreboard_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
